// File: rtl/tug_pkg.sv
// ---------------------------------------------------------------------------
// tug_pkg
// Shared definitions for the tug-of-war game block: the game state
// enumeration, the light-position and score constants, and a helper that
// turns a light position into its one-hot LED pattern.
// ---------------------------------------------------------------------------
package tug_pkg;

    typedef enum logic [2:0] {
        ST_PLAY   = 3'd0,
        ST_WIN_L  = 3'd1,
        ST_WIN_R  = 3'd2,
        ST_OVER_L = 3'd3,
        ST_OVER_R = 3'd4
    } state_t;

    localparam int POS_CENTER = 4;
    localparam int POS_MAX    = 8;
    localparam int SCORE_MAX  = 7;

    // led[8] is the leftmost light, so position 8 maps to bit 8.
    function automatic logic [8:0] pos_onehot(input logic [3:0] pos);
        logic [8:0] one;
        one = 9'd1;
        return one << pos;
    endfunction

endpackage

// File: rtl/tug_score_counter.sv
// ---------------------------------------------------------------------------
// tug_score_counter
// Three-bit round counter for one player. Counts up by one on each cycle
// that inc is high and saturates at SCORE_MAX, so it can never wrap.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high reset (count -> 0)
//   inc     in   count one round win this cycle
//   count   out  rounds won, 0..7
//   at_max  out  high while count equals SCORE_MAX
// ---------------------------------------------------------------------------
module tug_score_counter
    import tug_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    output logic [2:0] count,
    output logic       at_max
);

    assign at_max = (count == 3'(SCORE_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 3'd0;
        end else if (inc && !at_max) begin
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/tug_field.sv
// ---------------------------------------------------------------------------
// tug_field
// Tug-of-war game core. A light sits on a nine-position field; left presses
// pull it left, right presses pull it right. Pulling the light off either
// end wins a round for that player, shown for HOLD_CYCLES cycles before the
// light is recentred. The first player to seven rounds wins the match and
// the block freezes until reset.
//
// All outputs come straight from registers; no input reaches an output
// combinationally.
//
// Parameters:
//   HOLD_CYCLES  cycles a round win is displayed (1..255)
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   l_press     in   single-cycle press pulse, left player
//   r_press     in   single-cycle press pulse, right player
//   led         out  one-hot light position, led[8] leftmost; 0 outside play
//   win_l       out  left player's round or match win is being shown
//   win_r       out  right player's round or match win is being shown
//   score_l     out  left rounds won, 0..7
//   score_r     out  right rounds won, 0..7
//   match_over  out  a player has reached seven rounds
// ---------------------------------------------------------------------------
module tug_field
    import tug_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       l_press,
    input  logic       r_press,
    output logic [8:0] led,
    output logic       win_l,
    output logic       win_r,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic       match_over
);

    state_t      state;
    state_t      state_n;
    logic [3:0]  pos;
    logic [3:0]  pos_n;
    logic [7:0]  hold;
    logic [7:0]  hold_n;
    logic        inc_l;
    logic        inc_r;
    logic        max_l;
    logic        max_r;
    logic        l_only;
    logic        r_only;

    // Simultaneous presses cancel out: neither moves the light nor wins.
    assign l_only = l_press & ~r_press;
    assign r_only = r_press & ~l_press;

    tug_score_counter u_score_l (
        .clk    (clk),
        .reset  (reset),
        .inc    (inc_l),
        .count  (score_l),
        .at_max (max_l)
    );

    tug_score_counter u_score_r (
        .clk    (clk),
        .reset  (reset),
        .inc    (inc_r),
        .count  (score_r),
        .at_max (max_r)
    );

    always_comb begin
        state_n = state;
        pos_n   = pos;
        hold_n  = hold;
        inc_l   = 1'b0;
        inc_r   = 1'b0;

        case (state)
            ST_PLAY: begin
                if (l_only) begin
                    if (pos == 4'(POS_MAX)) begin
                        inc_l  = ~max_l;
                        // The counter updates on this same edge, so the
                        // match is decided by the pre-increment value.
                        state_n = (score_l == 3'(SCORE_MAX - 1)) ? ST_OVER_L : ST_WIN_L;
                        hold_n  = 8'(HOLD_CYCLES - 1);
                    end else begin
                        pos_n = pos + 4'd1;
                    end
                end else if (r_only) begin
                    if (pos == 4'd0) begin
                        inc_r   = ~max_r;
                        state_n = (score_r == 3'(SCORE_MAX - 1)) ? ST_OVER_R : ST_WIN_R;
                        hold_n  = 8'(HOLD_CYCLES - 1);
                    end else begin
                        pos_n = pos - 4'd1;
                    end
                end
            end

            ST_WIN_L, ST_WIN_R: begin
                // Loaded with HOLD_CYCLES-1 on entry; leaving on the zero
                // count makes the win visible for exactly HOLD_CYCLES cycles.
                if (hold == 8'd0) begin
                    state_n = ST_PLAY;
                    pos_n   = 4'(POS_CENTER);
                end else begin
                    hold_n = hold - 8'd1;
                end
            end

            default: begin
                // Match over: frozen until reset.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_PLAY;
            pos        <= 4'(POS_CENTER);
            hold       <= 8'd0;
            led        <= pos_onehot(4'(POS_CENTER));
            win_l      <= 1'b0;
            win_r      <= 1'b0;
            match_over <= 1'b0;
        end else begin
            state      <= state_n;
            pos        <= pos_n;
            hold       <= hold_n;
            // Outputs are registered from the next-state values so they line
            // up with the state they describe.
            led        <= (state_n == ST_PLAY) ? pos_onehot(pos_n) : 9'd0;
            win_l      <= (state_n == ST_WIN_L) || (state_n == ST_OVER_L);
            win_r      <= (state_n == ST_WIN_R) || (state_n == ST_OVER_R);
            match_over <= (state_n == ST_OVER_L) || (state_n == ST_OVER_R);
        end
    end

endmodule

// File: tb/tb_tug_field.sv
module tb_tug_field;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       l_press = 1'b0;
    logic       r_press = 1'b0;
    logic [8:0] led;
    logic       win_l;
    logic       win_r;
    logic [2:0] score_l;
    logic [2:0] score_r;
    logic       match_over;

    int checks = 0;
    int failures = 0;

    // Reference model: game phase, light position, rounds, and how many
    // more cycles the current round-win display remains on screen.
    // m_phase: 0 = playing, 1 = left round shown, 2 = right round shown,
    //          3 = left won match, 4 = right won match
    int m_phase;
    int m_pos;
    int m_sl;
    int m_sr;
    int m_left;

    tug_field #(.HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .l_press    (l_press),
        .r_press    (r_press),
        .led        (led),
        .win_l      (win_l),
        .win_r      (win_r),
        .score_l    (score_l),
        .score_r    (score_r),
        .match_over (match_over)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit l, input bit r, input bit rs);
        if (rs) begin
            m_phase = 0; m_pos = 4; m_sl = 0; m_sr = 0; m_left = 0;
        end else if (m_phase == 0) begin
            if (l && !r) begin
                if (m_pos < 8) m_pos++;
                else begin
                    m_sl++;
                    m_phase = (m_sl == 7) ? 3 : 1;
                    m_left = HOLD;
                end
            end else if (r && !l) begin
                if (m_pos > 0) m_pos--;
                else begin
                    m_sr++;
                    m_phase = (m_sr == 7) ? 4 : 2;
                    m_left = HOLD;
                end
            end
        end else if (m_phase == 1 || m_phase == 2) begin
            m_left--;
            if (m_left == 0) begin
                m_phase = 0;
                m_pos = 4;
            end
        end
    endtask

    function automatic logic [8:0] exp_led();
        logic [8:0] v;
        v = 9'd0;
        if (m_phase == 0) v[m_pos] = 1'b1;
        return v;
    endfunction

    // One clock cycle: drive on the falling edge, let the rising edge
    // capture, then release the pulses just after it.
    task automatic cycle(input bit l, input bit r, input bit rs);
        @(negedge clk);
        l_press = l;
        r_press = r;
        reset   = rs;
        @(posedge clk);
        model_step(l, r, rs);
        #1;
        l_press = 1'b0;
        r_press = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_reset();
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        checks++;
        if (led !== 9'b000010000) begin failures++; $display("FAIL reset_led got=%b want=%b", led, 9'b000010000); end
        checks++;
        if ({win_l, win_r, match_over} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {win_l, win_r, match_over}); end
        checks++;
        if ({score_l, score_r} !== 6'd0) begin failures++; $display("FAIL reset_scores got=%0d/%0d want=0/0", score_l, score_r); end
    endtask

    task automatic test_walk_left();
        logic [8:0] want [4];
        want[0] = 9'b000100000; want[1] = 9'b001000000;
        want[2] = 9'b010000000; want[3] = 9'b100000000;
        cycle(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0);
            checks++;
            if (led !== want[i]) begin failures++; $display("FAIL walk_led step=%0d got=%b want=%b", i, led, want[i]); end
            checks++;
            if (win_l !== 1'b0) begin failures++; $display("FAIL walk_win_l step=%0d got=%b want=0", i, win_l); end
            cycle(0, 0, 0);
        end
    endtask

    task automatic test_round_win_left();
        int n;
        // Continues from position 8 left by test_walk_left.
        cycle(1, 0, 0);
        checks++;
        if (win_l !== 1'b1 || led !== 9'd0) begin failures++; $display("FAIL round_entry got win_l=%b led=%b want win_l=1 led=0", win_l, led); end
        checks++;
        if (score_l !== 3'd1) begin failures++; $display("FAIL round_score got=%0d want=1", score_l); end
        n = 1;
        while (win_l === 1'b1 && n < 20) begin
            cycle(0, 0, 0);
            if (win_l === 1'b1) n++;
        end
        checks++;
        if (n != HOLD) begin failures++; $display("FAIL round_hold_len got=%0d want=%0d", n, HOLD); end
        checks++;
        if (led !== 9'b000010000) begin failures++; $display("FAIL round_recentre got=%b want=%b", led, 9'b000010000); end
    endtask

    task automatic test_simultaneous();
        cycle(0, 0, 1);
        cycle(1, 1, 0);
        checks++;
        if (led !== 9'b000010000) begin failures++; $display("FAIL both_led got=%b want=%b", led, 9'b000010000); end
        checks++;
        if ({win_l, win_r} !== 2'b00) begin failures++; $display("FAIL both_win got=%b want=00", {win_l, win_r}); end
    endtask

    task automatic test_right_hold_ignored();
        int n;
        cycle(0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0);
        checks++;
        if (led !== 9'b000000001) begin failures++; $display("FAIL right_edge got=%b want=%b", led, 9'b000000001); end
        cycle(0, 1, 0);
        checks++;
        if (win_r !== 1'b1 || score_r !== 3'd1) begin failures++; $display("FAIL right_win got win_r=%b score_r=%0d want 1/1", win_r, score_r); end
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        n = 0;
        while (win_r === 1'b1 && n < 20) begin
            cycle(0, 0, 0);
            n++;
        end
        checks++;
        if (n != HOLD - 2) begin failures++; $display("FAIL right_hold_len got=%0d want=%0d", n, HOLD - 2); end
        checks++;
        if (score_r !== 3'd1 || led !== 9'b000010000) begin failures++; $display("FAIL right_after got score_r=%0d led=%b want 1/%b", score_r, led, 9'b000010000); end
    endtask

    task automatic test_match_over();
        cycle(0, 0, 1);
        for (int round = 1; round <= 7; round++) begin
            for (int i = 0; i < 5; i++) cycle(1, 0, 0);
            checks++;
            if (score_l !== 3'(round)) begin failures++; $display("FAIL match_round score_l got=%0d want=%0d", score_l, round); end
            if (round < 7) for (int i = 0; i < HOLD; i++) cycle(0, 0, 0);
        end
        checks++;
        if ({match_over, win_l, win_r} !== 3'b110 || score_l !== 3'd7 || led !== 9'd0) begin
            failures++;
            $display("FAIL match_final got mo=%b wl=%b wr=%b sl=%0d led=%b want 1 1 0 7 0", match_over, win_l, win_r, score_l, led);
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            checks++;
            if ({match_over, win_l, win_r, score_l, score_r, led} !== {3'b110, 3'd7, 3'd0, 9'd0}) begin
                failures++;
                $display("FAIL match_frozen cyc=%0d got mo=%b wl=%b wr=%b sl=%0d sr=%0d led=%b", i, match_over, win_l, win_r, score_l, score_r, led);
            end
        end
    endtask

    task automatic test_reset_during_hold();
        cycle(0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0);
        checks++;
        if (win_l !== 1'b1) begin failures++; $display("FAIL hold_setup win_l got=%b want=1", win_l); end
        cycle(1, 0, 1);
        checks++;
        if ({led, win_l, win_r, match_over, score_l, score_r} !== {9'b000010000, 3'b000, 6'd0}) begin
            failures++;
            $display("FAIL reset_in_hold got led=%b wl=%b wr=%b mo=%b sl=%0d sr=%0d", led, win_l, win_r, match_over, score_l, score_r);
        end
    endtask

    task automatic test_random();
        bit l, r, rs;
        cycle(0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            l  = ($urandom_range(0, 99) < 45);
            r  = ($urandom_range(0, 99) < 35);
            rs = ($urandom_range(0, 399) == 0);
            cycle(l, r, rs);
            checks++;
            if (led !== exp_led()) begin failures++; $display("FAIL rand_led cyc=%0d got=%b want=%b", i, led, exp_led()); end
            checks++;
            if (win_l !== (m_phase == 1 || m_phase == 3)) begin failures++; $display("FAIL rand_win_l cyc=%0d got=%b want=%b", i, win_l, (m_phase == 1 || m_phase == 3)); end
            checks++;
            if (win_r !== (m_phase == 2 || m_phase == 4)) begin failures++; $display("FAIL rand_win_r cyc=%0d got=%b want=%b", i, win_r, (m_phase == 2 || m_phase == 4)); end
            checks++;
            if (match_over !== (m_phase >= 3)) begin failures++; $display("FAIL rand_match_over cyc=%0d got=%b want=%b", i, match_over, (m_phase >= 3)); end
            checks++;
            if (score_l !== 3'(m_sl) || score_r !== 3'(m_sr)) begin failures++; $display("FAIL rand_scores cyc=%0d got=%0d/%0d want=%0d/%0d", i, score_l, score_r, m_sl, m_sr); end
        end
    endtask

    initial begin
        m_phase = 0; m_pos = 4; m_sl = 0; m_sr = 0; m_left = 0;
        test_reset();
        test_walk_left();
        test_round_win_left();
        test_simultaneous();
        test_right_hold_ignored();
        test_match_over();
        test_reset_during_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tug_field.md
TUG_FIELD -- requirements
Module: tug_field

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, number of cycles a round-win indication is held (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port l_press  input  1  single-cycle pulse from the left player's press converter.
REQ-005 SHALL have port r_press  input  1  single-cycle pulse from the right player's press converter.
REQ-006 SHALL have port led  output  9  one-hot light position; led[8] leftmost, led[0] rightmost.
REQ-007 SHALL have port win_l  output  1  high while the left player's win (round or match) is indicated.
REQ-008 SHALL have port win_r  output  1  high while the right player's win (round or match) is indicated.
REQ-009 SHALL have port score_l  output  3  left rounds won, 0..7.
REQ-010 SHALL have port score_r  output  3  right rounds won, 0..7.
REQ-011 SHALL have port match_over  output  1  high once either score reaches 7.

Function
REQ-012 SHALL implement states PLAY, WIN_L, WIN_R, OVER_L, OVER_R; all outputs are decoded from registered state only (no input-to-output combinational path).
REQ-013 SHALL hold position pos 0..8; in PLAY, led = one-hot(pos); in every other state led = 0.
REQ-014 In PLAY, l_press & ~r_press with pos<8 SHALL set pos <= pos+1; r_press & ~l_press with pos>0 SHALL set pos <= pos-1; visible on led the cycle after the pulse.
REQ-015 l_press & r_press in the same cycle SHALL cause no move and no win.
REQ-016 In PLAY, l_press & ~r_press with pos==8 SHALL be a left round win: score_l <= score_l+1 at that edge; next state OVER_L if the new score is 7, else WIN_L.
REQ-017 In PLAY, r_press & ~l_press with pos==0 SHALL be a right round win, mirroring REQ-016 with score_r, WIN_R, OVER_R.
REQ-018 On entry to WIN_L/WIN_R a hold counter SHALL load HOLD_CYCLES-1 and decrement every cycle; when it is 0 the next state is PLAY with pos <= 4, so the win state lasts exactly HOLD_CYCLES cycles.
REQ-019 In WIN_L/WIN_R/OVER_L/OVER_R, l_press and r_press SHALL be ignored.
REQ-020 OVER_L/OVER_R SHALL be terminal until reset.
REQ-021 win_l SHALL be high exactly in WIN_L and OVER_L; win_r exactly in WIN_R and OVER_R; match_over exactly in OVER_L and OVER_R.
REQ-022 Scores SHALL never wrap; increments occur only via REQ-016/017, so 7 is reached only on entry to an OVER state.

Reset
REQ-023 reset SHALL set state PLAY, pos 4 (led = 9'b000010000), score_l = score_r = 0, hold counter 0, win_l = win_r = match_over = 0.
REQ-024 reset SHALL take priority over all inputs, including in the same cycle as a press, and SHALL abort a win hold or match-over immediately.

Structure
REQ-025 A shared package tug_pkg SHALL hold the state enum and constants POS_CENTER=4, POS_MAX=8, SCORE_MAX=7.
REQ-026 One sub-module, tug_score_counter (3-bit counter with inc enable, synchronous reset, terminal flag at 7), SHALL be instantiated twice (left, right).

Verification
REQ-027 Reset, then 4 isolated l_press pulses -> led steps 9'b000100000, 001000000, 010000000, 100000000; win_l stays 0.
REQ-028 From pos 8, one l_press -> next cycle win_l=1, led=0, score_l=1; with HOLD_CYCLES=4 win_l high exactly 4 cycles, then led=9'b000010000.
REQ-029 At pos 4, l_press and r_press in the same cycle -> led unchanged at 9'b000010000.
REQ-030 From pos 0, r_press during the WIN_R hold -> ignored, score_r stays 1, pos returns to 4 after the hold.
REQ-031 Seven left round wins -> after the 7th, match_over=1, win_l=1, score_l=7; further presses change nothing until reset.
REQ-032 Assert reset during a WIN_L hold with l_press high in the same cycle -> next cycle all outputs equal their reset values (REQ-023).
